// File: rtl/ptpv2_clkmon_pkg.sv
// Shared definitions for the clock rate monitor: FSM encodings and the
// default edge-count bounds for a 1000-cycle window at 25 MHz.
package ptpv2_clkmon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_REPORT  = 2'd3
   } clkmon_state_e;

   // Expected toggle edges per 1000-cycle window (toggle = clk/16)
   localparam int XGE_MIN_CNT = 385;
   localparam int XGE_MAX_CNT = 395;
   localparam int GE_MIN_CNT  = 308;
   localparam int GE_MAX_CNT  = 317;
   localparam int FE_MIN_CNT  = 60;
   localparam int FE_MAX_CNT  = 65;

endpackage

// File: rtl/clk_mon_sync_edge.sv
// Synchronizer for an asynchronous toggle plus an any-edge pulse.
// A history flop after the last sync stage gives a clean XOR edge pulse,
// so a toggle shows up as a one-cycle o_edge SYNC_STAGES cycles later.
// SYNC_STAGES must be at least 2.
module clk_mon_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_last;

   // Shift the async level through the chain and keep one cycle of history
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_last <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_last <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_edge = r_sync[SYNC_STAGES-1] ^ r_last;

endmodule

// File: rtl/clk_rate_monitor.sv
// Clock frequency / activity monitor in the pbus_clk domain.
// Counts edges of a toggle from the monitored domain over a fixed window
// and flags slow, fast or stopped clocks.
// Optional macro CLK_RATE_MON_STICKY_EN: flags become sticky until clear_i.
// Note: an edge seen in REPORT is carried into the next window, so in
// back-to-back mode each window covers REPORT + WIN_CYCLES cycles of edges.
module clk_rate_monitor #(
   parameter int WIN_CYCLES  = 1000,
   parameter int CNT_W       = 16,
   parameter int STOP_CYCLES = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic             pbus_clk,
   input  logic             rst_sys,
   input  logic             mon_toggle_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] min_cnt_i,
   input  logic [CNT_W-1:0] max_cnt_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] edge_cnt_o,
   output logic             cnt_valid_o,
   output logic             rate_low_o,
   output logic             rate_high_o,
   output logic             clk_stopped_o
);
   import ptpv2_clkmon_pkg::*;

   localparam int WIN_W = $clog2(WIN_CYCLES);
   localparam int TMR_W = $clog2(STOP_CYCLES + 1);
   localparam int ARM_W = $clog2(SYNC_STAGES + 1);

   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);
   localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(STOP_CYCLES);

   clkmon_state_e    r_state, w_next;
   logic             w_edge;
   logic             w_report;
   logic             w_tmr_full;
   logic [ARM_W-1:0] r_arm_cnt;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_edge_cnt;
   logic [CNT_W-1:0] r_min;
   logic [CNT_W-1:0] r_max;
   logic [TMR_W-1:0] r_tmr;
   logic [CNT_W-1:0] r_edge_cnt_o;
   logic             r_cnt_valid;
   logic             r_rate_low;
   logic             r_rate_high;

   clk_mon_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk   (pbus_clk),
      .i_rst   (rst_sys),
      .i_async (mon_toggle_i),
      .o_edge  (w_edge)
   );

   assign w_report   = (r_state == ST_REPORT);
   assign w_tmr_full = (r_tmr == TMR_FULL);

   // FSM state register
   always_ff @(posedge pbus_clk) begin
      if (rst_sys) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // FSM next state: dropping enable aborts ARM/MEASURE without a report
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:    if (enable_i) w_next = ST_ARM;
         ST_ARM:     if (!enable_i) w_next = ST_IDLE;
                     else if (r_arm_cnt == ARM_LAST) w_next = ST_MEASURE;
         ST_MEASURE: if (!enable_i) w_next = ST_IDLE;
                     else if (r_win_cnt == WIN_LAST) w_next = ST_REPORT;
         ST_REPORT:  w_next = enable_i ? ST_MEASURE : ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Window, arm, edge and stop counters; bounds latched at each window start
   always_ff @(posedge pbus_clk) begin
      if (rst_sys) begin
         r_arm_cnt  <= '0;
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_min      <= '0;
         r_max      <= '0;
         r_tmr      <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_arm_cnt <= '0;
               r_win_cnt <= '0;
            end
            ST_ARM: begin
               r_arm_cnt  <= r_arm_cnt + 1'b1;
               r_win_cnt  <= '0;
               r_edge_cnt <= '0;
               r_tmr      <= '0;
               r_min      <= min_cnt_i;
               r_max      <= max_cnt_i;
            end
            ST_MEASURE: begin
               r_win_cnt <= (r_win_cnt == WIN_LAST) ? '0 : r_win_cnt + 1'b1;
               if (w_edge && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + 1'b1;
               if (w_edge)           r_tmr <= '0;
               else if (!w_tmr_full) r_tmr <= r_tmr + 1'b1;
            end
            ST_REPORT: begin
               r_arm_cnt  <= '0;
               r_win_cnt  <= '0;
               r_edge_cnt <= w_edge ? CNT_W'(1) : '0;
               r_min      <= min_cnt_i;
               r_max      <= max_cnt_i;
            end
            default: r_arm_cnt <= '0;
         endcase
      end
   end

   // Publish the window result and the rate flags
   always_ff @(posedge pbus_clk) begin
      if (rst_sys) begin
         r_edge_cnt_o <= '0;
         r_cnt_valid  <= 1'b0;
         r_rate_low   <= 1'b0;
         r_rate_high  <= 1'b0;
      end else begin
         r_cnt_valid <= w_report;
         if (w_report) r_edge_cnt_o <= r_edge_cnt;
`ifdef CLK_RATE_MON_STICKY_EN
         if (w_report && (r_edge_cnt < r_min)) r_rate_low <= 1'b1;
         else if (clear_i)                     r_rate_low <= 1'b0;
         if (w_report && (r_edge_cnt > r_max)) r_rate_high <= 1'b1;
         else if (clear_i)                     r_rate_high <= 1'b0;
`else
         if (w_report) begin
            r_rate_low  <= (r_edge_cnt < r_min);
            r_rate_high <= (r_edge_cnt > r_max);
         end
`endif
      end
   end

`ifdef CLK_RATE_MON_STICKY_EN
   logic r_stop_stk;

   // Stopped flag latches until cleared; a live stop overrides the clear
   always_ff @(posedge pbus_clk) begin
      if (rst_sys)         r_stop_stk <= 1'b0;
      else if (w_tmr_full) r_stop_stk <= 1'b1;
      else if (clear_i)    r_stop_stk <= 1'b0;
   end

   assign clk_stopped_o = w_tmr_full | r_stop_stk;
`else
   logic w_unused_clear;
   assign w_unused_clear = clear_i;
   assign clk_stopped_o  = w_tmr_full;
`endif

   assign edge_cnt_o  = r_edge_cnt_o;
   assign cnt_valid_o = r_cnt_valid;
   assign rate_low_o  = r_rate_low;
   assign rate_high_o = r_rate_high;

endmodule

// File: tb/tb_clk_rate_monitor.sv
// Self-checking bench for clk_rate_monitor.
// The toggle is modelled with a fractional accumulator: rate = toggle flips
// per 1e6 pbus cycles. Back-to-back windows see edges from REPORT plus 1000
// MEASURE cycles (1001 cycles), the first window after ARM sees 1000.
module tb_clk_rate_monitor;

   logic        pbus_clk = 1'b0;
   logic        rst_sys = 1'b1;
   logic        mon_toggle_i = 1'b0;
   logic        enable_i = 1'b0;
   logic        clear_i = 1'b0;
   logic [15:0] min_cnt_i = '0;
   logic [15:0] max_cnt_i = '0;
   logic [15:0] edge_cnt_o;
   logic        cnt_valid_o, rate_low_o, rate_high_o, clk_stopped_o;
   logic [7:0]  sat_cnt;
   logic        sat_valid, sat_low, sat_high, sat_stop;

   int n_tests = 0;
   int n_fail  = 0;
   int rate    = 0;
   int acc     = 0;

   always #20 pbus_clk = ~pbus_clk;

   clk_rate_monitor dut (
      .pbus_clk(pbus_clk), .rst_sys(rst_sys), .mon_toggle_i(mon_toggle_i),
      .enable_i(enable_i), .min_cnt_i(min_cnt_i), .max_cnt_i(max_cnt_i),
      .clear_i(clear_i), .edge_cnt_o(edge_cnt_o), .cnt_valid_o(cnt_valid_o),
      .rate_low_o(rate_low_o), .rate_high_o(rate_high_o),
      .clk_stopped_o(clk_stopped_o)
   );

   // Narrow counter copy, used to exercise saturation
   clk_rate_monitor #(.CNT_W(8)) dut_sat (
      .pbus_clk(pbus_clk), .rst_sys(rst_sys), .mon_toggle_i(mon_toggle_i),
      .enable_i(enable_i), .min_cnt_i(min_cnt_i[7:0]), .max_cnt_i(max_cnt_i[7:0]),
      .clear_i(clear_i), .edge_cnt_o(sat_cnt), .cnt_valid_o(sat_valid),
      .rate_low_o(sat_low), .rate_high_o(sat_high), .clk_stopped_o(sat_stop)
   );

   typedef struct {
      string nm;
      int    rate;
      int    mn;
      int    mx;
      int    lo;
      int    hi;
      bit    low;
      bit    high;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // One pbus cycle: advance the toggle model, sample 1 ns after the edge
   task automatic tick();
      @(negedge pbus_clk);
      if (rate != 0) begin
         acc += rate;
         if (acc >= 1000000) begin
            acc -= 1000000;
            mon_toggle_i = ~mon_toggle_i;
         end
      end
      @(posedge pbus_clk);
      #1;
   endtask

   task automatic wait_valid(input string nm, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (cnt_valid_o !== 1'b1 && n < 3000);
      if (cnt_valid_o !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: no cnt_valid_o within %0d cycles", nm, n);
      end
   endtask

   task automatic clear_pulse();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   initial begin
      #2400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;

      //           name        rate     min   max   lo    hi   low high
      vecs[0] = '{"xge_ok",    390625,  385,  395,  391,  392, 0, 0};
      vecs[1] = '{"ge_slow",   312500,  385,  395,  312,  313, 1, 0};
      vecs[2] = '{"fast_200",  500000,  385,  395,  500,  501, 0, 1};
      vecs[3] = '{"ge_ok",     312500,  308,  317,  312,  313, 0, 0};
      vecs[4] = '{"fe_ok",     62500,   60,   65,   62,   63,  0, 0};
      vecs[5] = '{"min_gt_max",390625,  400,  300,  391,  392, 1, 1};
      vecs[6] = '{"max_edge",  1000000, 385,  1000, 1001, 1001,0, 1};
      vecs[7] = '{"eq_bounds", 1000000, 1001, 1001, 1001, 1001,0, 0};
      vecs[8] = '{"min_edge",  1000000, 1002, 2000, 1001, 1001,1, 0};

      // Reset state
      repeat (3) tick();
      chk("rst_edge_cnt", edge_cnt_o, 0);
      chk("rst_valid", cnt_valid_o, 0);
      chk("rst_low", rate_low_o, 0);
      chk("rst_high", rate_high_o, 0);
      chk("rst_stopped", clk_stopped_o, 0);
      rst_sys = 1'b0;
      tick();

      // Table-driven rate windows
      enable_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rate      = vecs[i].rate;
         min_cnt_i = 16'(vecs[i].mn);
         max_cnt_i = 16'(vecs[i].mx);
         wait_valid({vecs[i].nm, "_settle"}, n);
         clear_pulse();
         chk({vecs[i].nm, "_valid_width"}, cnt_valid_o, 0);
         wait_valid(vecs[i].nm, n);
         chk({vecs[i].nm, "_period"}, n + 1, 1001);
         chk_rng({vecs[i].nm, "_cnt"}, edge_cnt_o, vecs[i].lo, vecs[i].hi);
         chk({vecs[i].nm, "_low"}, rate_low_o, vecs[i].low);
         chk({vecs[i].nm, "_high"}, rate_high_o, vecs[i].high);
         chk_rng({vecs[i].nm, "_sat_cnt"}, sat_cnt,
                 (vecs[i].lo > 255) ? 255 : vecs[i].lo,
                 (vecs[i].hi > 255) ? 255 : vecs[i].hi);
      end

      // Stopped clock: single edge, then silence for 200 cycles
      wait_valid("stop_align", n);
      rate = 0;
      repeat (10) tick();
      mon_toggle_i = ~mon_toggle_i;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (k == 66)  chk("stop_before_64", clk_stopped_o, 0);
         if (k == 67)  chk("stop_at_64", clk_stopped_o, 1);
         if (k == 200) chk("stop_held", clk_stopped_o, 1);
      end
      mon_toggle_i = ~mon_toggle_i;
      tick();
      tick();
      chk("stop_resume_2", clk_stopped_o, 1);
      tick();
`ifdef CLK_RATE_MON_STICKY_EN
      chk("stop_sticky", clk_stopped_o, 1);
      clear_pulse();
      chk("stop_cleared", clk_stopped_o, 0);
`else
      chk("stop_resume_3", clk_stopped_o, 0);
`endif

      // enable_i dropped mid-window
      rate      = 390625;
      min_cnt_i = 16'd385;
      max_cnt_i = 16'd395;
      wait_valid("abort_settle", n);
      wait_valid("abort_clean", n);
      clear_pulse();
      chk_rng("abort_pre_cnt", edge_cnt_o, 391, 392);
      repeat (499) tick();
      enable_i = 1'b0;
      seen = 0;
      repeat (1200) begin
         tick();
         if (cnt_valid_o) seen = 1;
      end
      chk("abort_no_valid", seen, 0);
      chk_rng("abort_cnt_kept", edge_cnt_o, 391, 392);
      chk("abort_low_kept", rate_low_o, 0);
      chk("abort_high_kept", rate_high_o, 0);
      enable_i = 1'b1;
      wait_valid("reenable", n);
      chk("reenable_latency", n, 1004);
      chk_rng("reenable_cnt", edge_cnt_o, 390, 391);

      // Reset pulse mid-window
      min_cnt_i = 16'd400;
      max_cnt_i = 16'd410;
      wait_valid("rst_settle", n);
      wait_valid("rst_clean", n);
      chk("pre_rst_low", rate_low_o, 1);
      repeat (300) tick();
      rst_sys  = 1'b1;
      enable_i = 1'b0;
      tick();
      rst_sys = 1'b0;
      chk("midrst_edge_cnt", edge_cnt_o, 0);
      chk("midrst_valid", cnt_valid_o, 0);
      chk("midrst_low", rate_low_o, 0);
      chk("midrst_high", rate_high_o, 0);
      chk("midrst_stopped", clk_stopped_o, 0);
      seen = 0;
      repeat (50) begin
         tick();
         if (cnt_valid_o) seen = 1;
      end
      chk("midrst_idle_no_valid", seen, 0);
      enable_i = 1'b1;
      wait_valid("postrst", n);
      chk("postrst_latency", n, 1004);
      chk_rng("postrst_cnt", edge_cnt_o, 390, 391);
      chk("postrst_low", rate_low_o, 1);

`ifdef CLK_RATE_MON_STICKY_EN
      // Sticky rate_high survives good windows until cleared
      min_cnt_i = 16'd385;
      max_cnt_i = 16'd395;
      rate      = 500000;
      clear_pulse();
      wait_valid("stk_fast_settle", n);
      wait_valid("stk_fast", n);
      chk("stk_high_set", rate_high_o, 1);
      rate = 390625;
      wait_valid("stk_good_settle", n);
      wait_valid("stk_good", n);
      chk("stk_high_held", rate_high_o, 1);
      chk("stk_low_clear", rate_low_o, 0);
      clear_pulse();
      chk("stk_high_cleared", rate_high_o, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
